// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the FP arithmetic datapath.
package fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIVIDE,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_div_classify.sv
// Combinational operand classifier for the FP divider: detects NaN/inf/zero cases
// (denormals count as zero) and produces the final special-case quotient.
module fp_div_classify
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        special_hit,
    output logic [31:0] special_q,
    output logic        special_dbz
);

    fp32_t fa;
    fp32_t fb;
    logic  a_zero, a_inf, a_nan;
    logic  b_zero, b_inf, b_nan;
    logic  sign;

    assign fa = a;
    assign fb = b;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        a_zero      = (fa.exp == 8'h00);
        a_inf       = (fa.exp == FP_INF_EXP) && (fa.man == 23'd0);
        a_nan       = (fa.exp == FP_INF_EXP) && (fa.man != 23'd0);
        b_zero      = (fb.exp == 8'h00);
        b_inf       = (fb.exp == FP_INF_EXP) && (fb.man == 23'd0);
        b_nan       = (fb.exp == FP_INF_EXP) && (fb.man != 23'd0);
        sign        = fa.sign ^ fb.sign;
        special_hit = 1'b1;
        special_dbz = 1'b0;
        special_q   = FP_QNAN;

        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_q = FP_QNAN;
        end else if (a_inf) begin
            special_q = {sign, FP_INF_EXP, 23'd0};
        end else if (b_inf || a_zero) begin
            special_q = {sign, 31'd0};
        end else if (b_zero) begin
            special_q   = {sign, FP_INF_EXP, 23'd0};
            special_dbz = 1'b1;
        end else begin
            special_hit = 1'b0;
            special_q   = 32'd0;
        end
    end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single divider q = a / b, one restoring quotient bit per clock.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_divider_seq
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] q,
    output logic        div_by_zero
);

    localparam int CW = $clog2(QBITS + 1);
    localparam int QW = QBITS - 1;

    state_t              state;
    logic [CW-1:0]       cnt;

    fp32_t               a_r, b_r;
    logic                sign_r;
    logic signed [9:0]   e_r;
    logic [23:0]         mb_r;
    logic [24:0]         rem_r;
    logic [QBITS-1:0]    quo_r;

    logic                special_hit, special_dbz;
    logic [31:0]         special_q;

    logic                ge;
    logic [23:0]         rem_sub;
    logic signed [9:0]   e_norm, e_final;
    logic [22:0]         frac;
    logic                round_up;
    logic [23:0]         frac_sum;
    logic [31:0]         norm_q;

    fp_div_classify u_classify (
        .a           (a),
        .b           (b),
        .special_hit (special_hit),
        .special_q   (special_q),
        .special_dbz (special_dbz)
    );

    // One restoring step: the remainder stays below 2*mb, so it always fits 25 bits.
    always_comb begin
        ge      = (rem_r >= {1'b0, mb_r});
        rem_sub = ge ? 24'(rem_r - {1'b0, mb_r}) : rem_r[23:0];
    end

`ifdef FP_DIV_RNE_EN
    localparam logic [QW-1:0] LOW_MASK = (QW'(1) << (QBITS - 25)) - QW'(1);
    logic [QW-1:0] qs;
    logic          guard, sticky;

    always_comb begin
        qs       = quo_r[QBITS-1] ? quo_r[QBITS-2:0] : {quo_r[QBITS-3:0], 1'b0};
        frac     = qs[QW-1 -: 23];
        guard    = qs[QBITS-25];
        sticky   = (|(qs & LOW_MASK)) | (|rem_r);
        round_up = guard & (sticky | frac[0]);
    end
`else
    always_comb begin
        frac     = quo_r[QBITS-1] ? quo_r[QBITS-2 -: 23] : quo_r[QBITS-3 -: 23];
        round_up = 1'b0;
    end
`endif

    // Underflow is judged before rounding, overflow after the rounding carry.
    always_comb begin
        e_norm   = quo_r[QBITS-1] ? e_r : e_r - 10'sd1;
        frac_sum = {1'b0, frac} + 24'(round_up);
        e_final  = e_norm + $signed({9'd0, frac_sum[23]});
        norm_q   = {sign_r, e_final[7:0], frac_sum[22:0]};
        if (e_norm <= 10'sd0) begin
            norm_q = {sign_r, 31'd0};
        end else if (e_final >= 10'sd255) begin
            norm_q = {sign_r, FP_INF_EXP, 23'd0};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            q           <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        if (special_hit) begin
                            q           <= special_q;
                            div_by_zero <= special_dbz;
                            state       <= SPECIAL;
                        end else begin
                            state <= DIVIDE;
                        end
                    end
                end
                SPECIAL: begin
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DIVIDE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(QBITS)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    q           <= norm_q;
                    div_by_zero <= 1'b0;
                    out_valid   <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never consumes them before loading them.
    // Cycle 0 of DIVIDE unpacks the captured operands, cycles 1..QBITS each produce one quotient bit.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_r <= a;
                    b_r <= b;
                end
            end
            DIVIDE: begin
                if (cnt == '0) begin
                    sign_r <= a_r.sign ^ b_r.sign;
                    e_r    <= 10'({2'b00, a_r.exp}) - 10'({2'b00, b_r.exp}) + 10'(FP_BIAS);
                    rem_r  <= {2'b01, a_r.man};
                    mb_r   <= {1'b1, b_r.man};
                end else begin
                    rem_r <= {rem_sub, 1'b0};
                    quo_r <= {quo_r[QBITS-2:0], ge};
                end
            end
            default: ;
        endcase
    end

endmodule
